// File: rtl/cond_pkg.sv
// Shared types for the EX-stage condition/flag logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the ARM condition-code enum, NZCV bit positions within the 4-bit
// flag vector, and the branch-shadow FSM state type.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Bit positions inside the flag vector: {N, Z, C, V}.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_e;

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluator: decides whether a 4-bit ARM condition passes.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   cond_i  - 4-bit condition field
//   flags_i - NZCV vector, bit order [3]=N [2]=Z [1]=C [0]=V
//   pass_o  - 1 when the condition holds for the given flags
// Stateless so the decode stage can reuse it for static branch prediction.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = flags_i[FLAG_N];
  assign w_z = flags_i[FLAG_Z];
  assign w_c = flags_i[FLAG_C];
  assign w_v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b1;
    case (cond_e'(cond_i))
      COND_EQ: pass_o = w_z;
      COND_NE: pass_o = ~w_z;
      COND_CS: pass_o = w_c;
      COND_CC: pass_o = ~w_c;
      COND_MI: pass_o = w_n;
      COND_PL: pass_o = ~w_n;
      COND_VS: pass_o = w_v;
      COND_VC: pass_o = ~w_v;
      COND_HI: pass_o = w_c & ~w_z;
      COND_LS: pass_o = ~w_c | w_z;
      COND_GE: pass_o = (w_n == w_v);
      COND_LT: pass_o = (w_n != w_v);
      COND_GT: pass_o = ~w_z & (w_n == w_v);
      COND_LE: pass_o = w_z | (w_n != w_v);
      // AL and the NV encoding both execute unconditionally.
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// EX-stage NZCV register, condition gating of write/branch controls, and branch-shadow squash FSM.
// Latency: gated controls are combinational (0 cycles); flag updates are visible to the next instruction (1 cycle).
// Backpressure: stall_i holds all state and re-presents the instruction; flush_i squashes and returns the FSM to RUN.
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   stall_i, flush_i            - EX hold / external squash
//   valid_i, cond_i             - instruction valid and its condition field
//   flag_write_i                - [1] updates N,Z  [0] updates C,V
//   alu_flags_i                 - ALU result flags {N,Z,C,V}
//   pcsrc_i/reg_write_i/mem_write_i - raw controls; *_o are the gated versions
//   cond_ex_o                   - instruction executes this cycle
//   flags_o                     - architectural NZCV register
//   shadow_o                    - FSM is squashing wrong-path instructions
//   exec_cnt_o, squash_cnt_o    - statistics, live only when COND_STATS_EN is defined
// Optional feature macro: COND_STATS_EN (statistics counters; tied to 0 when undefined).
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int SHADOW = 2,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_write_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             pcsrc_i,
  input  logic             reg_write_i,
  input  logic             mem_write_i,
  output logic             pcsrc_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             cond_ex_o,
  output logic [3:0]       flags_o,
  output logic             shadow_o,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
);

  localparam logic [2:0] SHADOW_LD = 3'(SHADOW);

  logic [3:0] r_flags;
  state_e     r_state;
  logic [2:0] r_cnt;
  logic       w_pass;
  logic       w_exec;

  cond_check u_cond_check (
    .cond_i  (cond_i),
    .flags_i (r_flags),
    .pass_o  (w_pass)
  );

  // rst_n is folded in so the gated controls read 0 while reset is held.
  assign w_exec = rst_n & valid_i & w_pass & ~stall_i & ~flush_i & (r_state != ST_SHADOW);

  assign cond_ex_o   = w_exec;
  assign pcsrc_o     = pcsrc_i & w_exec;
  assign reg_write_o = reg_write_i & w_exec;
  assign mem_write_o = mem_write_i & w_exec;
  assign flags_o     = r_flags;
  assign shadow_o    = (r_state == ST_SHADOW);

  // w_exec already excludes stall and flush, so flags only move on real executes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_exec) begin
      if (flag_write_i[1]) begin
        r_flags[FLAG_N] <= alu_flags_i[FLAG_N];
        r_flags[FLAG_Z] <= alu_flags_i[FLAG_Z];
      end
      if (flag_write_i[0]) begin
        r_flags[FLAG_C] <= alu_flags_i[FLAG_C];
        r_flags[FLAG_V] <= alu_flags_i[FLAG_V];
      end
    end
  end

  // Branch shadow: counts non-stalled cycles; leaving happens on the cycle the counter reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else if (flush_i) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exec & pcsrc_i) begin
            r_state <= ST_SHADOW;
            r_cnt   <= SHADOW_LD;
          end
        end
        ST_SHADOW: begin
          if (!stall_i) begin
            if (r_cnt <= 3'd1) begin
              r_state <= ST_RUN;
              r_cnt   <= 3'd0;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_squash_cnt;
  logic             w_squash;

  // Squash covers condition fail, shadow and flush; stalled cycles are not counted.
  assign w_squash = valid_i & ~stall_i & ~w_exec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exec_cnt   <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_exec)   r_exec_cnt   <= r_exec_cnt + CNT_W'(1);
      if (w_squash) r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end
  end

  assign exec_cnt_o   = r_exec_cnt;
  assign squash_cnt_o = r_squash_cnt;
`else
  assign exec_cnt_o   = '0;
  assign squash_cnt_o = '0;
`endif

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- EX-stage consumer of the 4-bit ALU flag vector.
- Holds the architectural NZCV register and evaluates the 4-bit ARM condition field of each EX-stage instruction against it.
- Gates the instruction's write/branch controls according to the condition result.
- Runs a branch-shadow FSM that squashes wrong-path instructions after a taken branch.
- Sits between the decode control pipeline register and the ALU/writeback controls of the pipelined processor.

Parameters:
- SHADOW, 2: number of non-stalled cycles after a taken branch during which incoming instructions are squashed (1..7).
- CNT_W, 32: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold EX stage; the instruction is re-presented next cycle
- flush_i  in  1  external flush (exception/redirect); squashes the current instruction
- valid_i  in  1  EX-stage instruction is valid
- cond_i  in  4  condition field
- flag_write_i  in  2  bit1 updates N,Z; bit0 updates C,V
- alu_flags_i  in  4  from ALU: [0]=V, [1]=C, [2]=Z, [3]=N
- pcsrc_i, reg_write_i, mem_write_i  in  1 each  raw decoded controls
- pcsrc_o, reg_write_o, mem_write_o  out  1 each  gated controls
- cond_ex_o  out  1  current instruction executes
- flags_o  out  4  registered NZCV, same bit order as alu_flags_i
- shadow_o  out  1  FSM is in SHADOW
- exec_cnt_o, squash_cnt_o  out  CNT_W each  statistics

Behaviour:
- Reset (async, rst_n=0): flags_o=4'b0000; FSM=RUN; shadow counter=0; stats counters=0.
- Combinational outputs settle to 0 during reset because valid_i is ignored.
- Condition decode uses flags_o, i.e. the registered flags of prior instructions:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 1
- Execute term: exec = valid_i & pass & !stall_i & !flush_i & !(state==SHADOW).
- cond_ex_o = exec. Each x_o = x_i & exec. This path is combinational, with 0 latency.
- Flag register: at the posedge where exec=1, N,Z <= alu_flags_i[3:2] if flag_write_i[1], and C,V <= alu_flags_i[1:0] if flag_write_i[0]. The new value is visible to the next instruction (1-cycle latency, no bypass needed).
- FSM states RUN and SHADOW:
  - RUN -> SHADOW when pcsrc_o=1; counter loads SHADOW.
  - In SHADOW, each cycle with stall_i=0 decrements the counter. At 1 -> RUN.
  - While in SHADOW, a valid_i=1 instruction is squashed and does not update flags.
  - Stalled cycles do not count.
  - shadow_o = (state==SHADOW), registered.
- Priority: rst_n > flush_i > stall_i > normal.
  - flush_i forces RUN and clears the counter next edge.
  - Flags are never written on flush or stall.
- A taken branch that also writes flags performs both: flags update and shadow entry on the same edge.
- A branch arriving inside SHADOW is squashed and does not extend the shadow.
- Condition fail with valid_i=1: all gated outputs 0, flags unchanged, counted as squashed.

Optional Feature:
- Macro COND_STATS_EN.
- Defined:
  - exec_cnt_o increments on each exec cycle.
  - squash_cnt_o increments on each cycle with valid_i & !stall_i & !exec, covering condition fail, shadow and flush.
  - Both counters wrap at 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package cond_pkg holds:
  - typedef enum for cond codes (EQ..AL, NV);
  - localparams for flag bit indices FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_N=3;
  - typedef enum for FSM state {RUN, SHADOW}.
- One natural sub-module, cond_check: a purely combinational decoder taking cond and flags and producing pass. It is reusable in the decode stage for static prediction.

Test Plan:
- Reset, then cond=EQ (0000), valid=1, reg_write_i=1 -> reg_write_o=0 because Z=0. After CMP-style writing alu_flags=4'b0100 with flag_write=2'b11, next EQ instruction -> reg_write_o=1, flags_o=4'b0100.
- Flags N=1,V=0 -> GE fails, LT passes. Then write only C,V with alu_flags=4'b0011 and flag_write=2'b01 -> flags_o=4'b1111 (N,Z retained).
- Taken AL branch with SHADOW=2 -> pcsrc_o=1, shadow_o high for 2 cycles. Two valid AL reg_write instructions -> reg_write_o=0. Third -> 1.
- Taken branch, then stall_i=1 for 3 cycles inside SHADOW -> shadow lasts 2 non-stalled cycles (5 total). No flag writes during the stall.
- flush_i=1 during SHADOW with valid AL instruction -> all outputs 0, shadow_o=0 next cycle. Drop rst_n mid-SHADOW -> flags_o=0 and shadow_o=0 immediately (async).
- With COND_STATS_EN: 5 executed, 3 condition-fail and 2 shadow-squashed instructions -> exec_cnt_o=5, squash_cnt_o=5. Preload-free wrap check at CNT_W=4: 17 executes -> exec_cnt_o=1.
